// File: rtl/stopwatch_bcd_display_pkg.sv
// rtl/stopwatch_bcd_display_pkg.sv - shared BCD width and active-low 7-segment patterns
package stopwatch_bcd_display_pkg;

    localparam int BCD_W = 4;

    // Patterns are {g,f,e,d,c,b,a}, a 0 lights the segment
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decoder
module bcd_to_seg7
    import stopwatch_bcd_display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Non-decimal codes blank the digit instead of showing garbage
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_bcd_display.sv
// rtl/stopwatch_bcd_display.sv - BCD stopwatch with multiplexed common-anode 7-segment output
module stopwatch_bcd_display
    import stopwatch_bcd_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100_000
) (
    input  logic                        clk_100MHz,
    input  logic                        reset,
    input  logic                        clk_10Hz,
    input  logic                        btn_start_stop,
    input  logic                        btn_clear,
    output logic                        running,
    output logic                        overflow,
    output logic [BCD_W*NUM_DIGITS-1:0] bcd_value,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [6:0]                  seg,
    output logic                        dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic             s1, s2, s3;
    logic             ss_q, clr_q;
    logic             tick, ss_pulse, clr_pulse, count_en;
    logic [BCD_W-1:0] digit      [NUM_DIGITS];
    logic [BCD_W-1:0] digit_next [NUM_DIGITS];
    logic             wrap;
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] scan_cnt;
    logic [6:0]       seg_dec;

    assign tick      = s2 & ~s3;
    assign ss_pulse  = btn_start_stop & ~ss_q;
    assign clr_pulse = btn_clear & ~clr_q;
    // Uses the pre-toggle running value so a coincident start/stop press does not gate this tick
    assign count_en  = running & tick;

    // Synchronise the 10 Hz wave and keep one history flop per button for edge detection
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            ss_q  <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            s1    <= clk_10Hz;
            s2    <= s1;
            s3    <= s2;
            ss_q  <= btn_start_stop;
            clr_q <= btn_clear;
        end
    end

    // Each start/stop press flips the run state
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            running <= 1'b0;
        end else if (ss_pulse) begin
            running <= ~running;
        end
    end

    // Ripple increment across the BCD digits; carry out of the top digit is the wrap
    always_comb begin
        logic carry;
        carry = count_en;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_next[i] = digit[i];
            if (carry) begin
                if (digit[i] == BCD_W'(9)) begin
                    digit_next[i] = '0;
                end else begin
                    digit_next[i] = digit[i] + BCD_W'(1);
                    carry         = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    // Digit and overflow state; clear beats a coincident tick
    always_ff @(posedge clk_100MHz) begin
        if (reset || clr_pulse) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= '0;
            end
            overflow <= 1'b0;
        end else if (count_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= digit_next[i];
            end
            if (wrap) begin
                overflow <= 1'b1;
            end
        end
    end

    // Expose the digit registers directly, d0 in the low nibble
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_value[i*BCD_W +: BCD_W] = digit[i];
        end
    end

    // Slot timer: every SCAN_DIV cycles move to the next digit
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (scan_idx == IDX_W'(NUM_DIGITS - 1)) begin
                scan_idx <= '0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (digit[scan_idx]),
        .seg (seg_dec)
    );

    // Register the pin drive so anode, segments and point switch together
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << scan_idx);
            seg <= seg_dec;
            dp  <= (scan_idx != IDX_W'(1));
        end
    end

endmodule
